// File: rtl/round_state_mux_if.sv
// Handshake and data bundle between the round-state mux and its environment.
// The master side drives block input, round-function feedback and flow control.
interface round_state_mux_if #(
  parameter int WORD_W = 32,
  parameter int NWORDS = 4,
  parameter int CNT_W  = 4
);
  localparam int DW = WORD_W * NWORDS;

  logic          abort;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [DW-1:0] fb_data;
  logic          key_valid;
  logic [DW-1:0] state_q;
  logic [CNT_W-1:0] round;
  logic          busy;
  logic          out_valid;
  logic          out_ready;

  modport master (
    output abort, in_valid, in_data, fb_data, key_valid, out_ready,
    input  in_ready, state_q, round, busy, out_valid
  );

  modport slave (
    input  abort, in_valid, in_data, fb_data, key_valid, out_ready,
    output in_ready, state_q, round, busy, out_valid
  );
endinterface

// File: rtl/round_state_mux.sv
// Holds the iterated block state: loads the initial block, then replaces all
// words with round-function feedback once per keyed round until the last round.
//
// state | meaning
// IDLE  | waiting for a block; in_ready high
// RUN   | applying rounds; advances only when key_valid is high
// DONE  | final state presented on state_q until out_ready
module round_state_mux #(
  parameter int WORD_W  = 32,
  parameter int NWORDS  = 4,
  parameter int NROUNDS = 10,
  parameter int CNT_W   = 4
) (
  input logic              clk,
  input logic              rst,
  round_state_mux_if.slave bus
);
  localparam int DW = WORD_W * NWORDS;
  localparam logic [CNT_W-1:0] LAST_ROUND = CNT_W'(NROUNDS);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } fsm_t;

  fsm_t             state, state_nxt;
  logic [DW-1:0]    data_r, data_nxt;
  logic [CNT_W-1:0] round_r, round_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      data_r  <= '0;
      round_r <= '0;
    end else begin
      state   <= state_nxt;
      data_r  <= data_nxt;
      round_r <= round_nxt;
    end
  end

  // Abort outranks every handshake; feedback replaces all words at once.
  always_comb begin
    state_nxt = state;
    data_nxt  = data_r;
    round_nxt = round_r;
    if (bus.abort) begin
      state_nxt = IDLE;
      data_nxt  = '0;
      round_nxt = '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            data_nxt  = bus.in_data;
            round_nxt = CNT_W'(1);
            state_nxt = RUN;
          end
        end
        RUN: begin
          if (bus.key_valid) begin
            data_nxt = bus.fb_data;
            if (round_r == LAST_ROUND) begin
              state_nxt = DONE;
            end else begin
              round_nxt = round_r + CNT_W'(1);
            end
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            round_nxt = '0;
            state_nxt = IDLE;
          end
        end
        default: begin
          state_nxt = IDLE;
          data_nxt  = '0;
          round_nxt = '0;
        end
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.busy      = (state == RUN);
  assign bus.out_valid = (state == DONE);
  assign bus.state_q   = data_r;
  assign bus.round     = round_r;
endmodule

// File: tb/tb_round_state_mux.sv
// Bench for round_state_mux: vector table, directed multi-cycle sequences and
// randomized blocks checked against a transaction-level round model.
module tb_round_state_mux;
  localparam int WORD_W  = 32;
  localparam int NWORDS  = 4;
  localparam int NROUNDS = 10;
  localparam int CNT_W   = 4;
  localparam int DW      = WORD_W * NWORDS;

  logic clk = 1'b0;
  logic rst;
  logic fb_mode;
  int   n_cmp = 0;
  int   n_bad = 0;

  round_state_mux_if #(.WORD_W(WORD_W), .NWORDS(NWORDS), .CNT_W(CNT_W)) bus ();

  round_state_mux #(
    .WORD_W(WORD_W), .NWORDS(NWORDS), .NROUNDS(NROUNDS), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] add_words(input logic [DW-1:0] s, input logic [31:0] n);
    logic [DW-1:0] o;
    for (int k = 0; k < NWORDS; k++) o[k*WORD_W +: WORD_W] = s[k*WORD_W +: WORD_W] + n;
    return o;
  endfunction

  function automatic logic [DW-1:0] rf(input logic [DW-1:0] s, input logic [CNT_W-1:0] r);
    logic [DW-1:0] o;
    logic [31:0]   w;
    for (int k = 0; k < NWORDS; k++) begin
      w = s[k*WORD_W +: WORD_W];
      w = {w[26:0], w[31:27]} ^ (32'h9E3779B9 + 32'(k));
      o[k*WORD_W +: WORD_W] = w + {28'd0, r};
    end
    return o;
  endfunction

  // Environment round function: increment mode for directed tests, mixing otherwise.
  assign bus.fb_data = fb_mode ? rf(bus.state_q, bus.round) : add_words(bus.state_q, 32'd1);

  task automatic chk_i(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_d(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.abort     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.key_valid = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  task automatic chk_idle(input string nm);
    chk_i({nm, "_ir"}, int'(bus.in_ready), 1);
    chk_i({nm, "_busy"}, int'(bus.busy), 0);
    chk_i({nm, "_ov"}, int'(bus.out_valid), 0);
    chk_i({nm, "_round"}, int'(bus.round), 0);
  endtask

  typedef struct {
    logic ab, iv, kv, ordy;
    logic e_ir, e_busy, e_ov;
    int   e_round;
    int   e_inc;
    logic e_zero;
  } vec_t;

  vec_t tv[9];

  logic [DW-1:0] d0, d1, da, db, exp_s, hold_s;
  int            n, cnt, guard;
  logic          aborted;

  initial begin
    tv[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1, 0, 1'b0};
    tv[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2, 1, 1'b0};
    tv[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2, 1, 1'b0};
    tv[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3, 2, 1'b0};
    tv[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b1};
    tv[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 1'b1};
    tv[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1, 0, 1'b0};
    tv[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b1};
    tv[8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1, 0, 1'b0};

    d0 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    d1 = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    fb_mode = 1'b0;

    // Reset values must appear without any clock edge.
    idle_inputs();
    rst = 1'b1;
    #2;
    chk_idle("reset");
    chk_d("reset_state", bus.state_q, '0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      bus.abort     = tv[i].ab;
      bus.in_valid  = tv[i].iv;
      bus.key_valid = tv[i].kv;
      bus.out_ready = tv[i].ordy;
      bus.in_data   = d0;
      tick();
      chk_i($sformatf("vec%0d_ir", i), int'(bus.in_ready), int'(tv[i].e_ir));
      chk_i($sformatf("vec%0d_busy", i), int'(bus.busy), int'(tv[i].e_busy));
      chk_i($sformatf("vec%0d_ov", i), int'(bus.out_valid), int'(tv[i].e_ov));
      chk_i($sformatf("vec%0d_round", i), int'(bus.round), tv[i].e_round);
      chk_d($sformatf("vec%0d_state", i), bus.state_q,
            tv[i].e_zero ? '0 : add_words(d0, 32'(tv[i].e_inc)));
    end
    idle_inputs();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;

    // Nominal: key_valid tied high, out_valid NROUNDS edges after accept.
    bus.in_valid = 1'b1;
    bus.in_data  = d0;
    tick();
    bus.in_valid  = 1'b0;
    bus.key_valid = 1'b1;
    n = 0;
    while (!bus.out_valid && n < 40) begin
      tick();
      n++;
    end
    chk_i("nom_latency", n, NROUNDS);
    chk_d("nom_state", bus.state_q, 128'h0011223D_44556681_8899AAC5_CCDDEF09);
    chk_i("nom_round", int'(bus.round), NROUNDS);
    bus.key_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk_idle("nom_ret");
    chk_d("nom_keep", bus.state_q, add_words(d0, 32'd10));

    // Stall at round 4 for three cycles.
    bus.in_valid = 1'b1;
    bus.in_data  = d1;
    tick();
    bus.in_valid  = 1'b0;
    bus.key_valid = 1'b1;
    n = 0;
    repeat (3) begin
      tick();
      n++;
    end
    chk_i("stall_round4", int'(bus.round), 4);
    hold_s = bus.state_q;
    bus.key_valid = 1'b0;
    repeat (3) begin
      tick();
      n++;
      chk_i("stall_round_hold", int'(bus.round), 4);
      chk_d("stall_state_hold", bus.state_q, hold_s);
    end
    bus.key_valid = 1'b1;
    while (!bus.out_valid && n < 60) begin
      tick();
      n++;
    end
    chk_i("stall_latency", n, NROUNDS + 3);
    chk_d("stall_state", bus.state_q, add_words(d1, 32'd10));
    bus.key_valid = 1'b0;

    // Backpressure in DONE; in_valid pulses must be ignored.
    bus.in_data = d0;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = i[0];
      tick();
      chk_d("bp_state", bus.state_q, add_words(d1, 32'd10));
      chk_i("bp_ir", int'(bus.in_ready), 0);
      chk_i("bp_ov", int'(bus.out_valid), 1);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk_idle("bp_ret");

    // Abort at round 6, then a fresh block.
    bus.in_valid = 1'b1;
    bus.in_data  = d0;
    tick();
    bus.in_valid  = 1'b0;
    bus.key_valid = 1'b1;
    repeat (5) tick();
    chk_i("abort_round6", int'(bus.round), 6);
    bus.abort    = 1'b1;
    bus.in_valid = 1'b1;
    tick();
    bus.abort    = 1'b0;
    bus.in_valid = 1'b0;
    chk_idle("abort");
    chk_d("abort_state", bus.state_q, '0);
    bus.in_valid = 1'b1;
    bus.in_data  = d1;
    tick();
    bus.in_valid = 1'b0;
    chk_i("abort_new_round", int'(bus.round), 1);
    chk_d("abort_new_state", bus.state_q, d1);

    // Async reset pulse between edges during RUN.
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk_idle("arst");
    chk_d("arst_state", bus.state_q, '0);
    @(negedge clk);
    rst = 1'b0;
    bus.key_valid = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = d0;
    tick();
    bus.in_valid = 1'b0;
    chk_i("arst_after_round", int'(bus.round), 1);
    chk_d("arst_after_state", bus.state_q, d0);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;

    // Back-to-back with in_valid held high.
    da = 128'h11111111_22222222_33333333_44444444;
    db = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;
    bus.in_valid  = 1'b1;
    bus.in_data   = da;
    bus.key_valid = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    chk_d("b2b_first", bus.state_q, da);
    bus.in_data = db;
    repeat (NROUNDS) tick();
    chk_i("b2b_done", int'(bus.out_valid), 1);
    chk_d("b2b_final", bus.state_q, add_words(da, 32'd10));
    tick();
    chk_idle("b2b_idle");
    tick();
    chk_i("b2b_busy", int'(bus.busy), 1);
    chk_i("b2b_round", int'(bus.round), 1);
    chk_d("b2b_second", bus.state_q, db);
    idle_inputs();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;

    // Randomized blocks against the transaction-level model.
    fb_mode = 1'b1;
    for (int b = 0; b < 30; b++) begin
      da = {$urandom, $urandom, $urandom, $urandom};
      exp_s = da;
      for (int r = 1; r <= NROUNDS; r++) exp_s = rf(exp_s, CNT_W'(r));
      bus.in_valid  = 1'b1;
      bus.in_data   = da;
      bus.key_valid = 1'($urandom_range(0, 1));
      tick();
      bus.in_valid = 1'b0;
      chk_i("rnd_accept_round", int'(bus.round), 1);
      chk_d("rnd_accept_state", bus.state_q, da);
      cnt = 0;
      guard = 0;
      aborted = 1'b0;
      while (cnt < NROUNDS && guard < 300 && !aborted) begin
        bus.key_valid = ($urandom_range(0, 3) != 0);
        bus.abort     = ($urandom_range(0, 79) == 0);
        bus.in_valid  = 1'($urandom_range(0, 1));
        bus.out_ready = 1'($urandom_range(0, 1));
        bus.in_data   = {$urandom, $urandom, $urandom, $urandom};
        tick();
        guard++;
        if (bus.abort) begin
          aborted = 1'b1;
          chk_idle("rnd_abort");
          chk_d("rnd_abort_state", bus.state_q, '0);
        end else begin
          if (bus.key_valid) cnt++;
          if (cnt < NROUNDS) begin
            chk_i("rnd_round", int'(bus.round), cnt + 1);
            chk_i("rnd_busy", int'(bus.busy), 1);
          end
        end
      end
      idle_inputs();
      if (!aborted) begin
        chk_i("rnd_budget", cnt, NROUNDS);
        chk_i("rnd_ov", int'(bus.out_valid), 1);
        chk_i("rnd_final_round", int'(bus.round), NROUNDS);
        chk_d("rnd_final", bus.state_q, exp_s);
        repeat ($urandom_range(0, 3)) begin
          bus.key_valid = 1'b1;
          bus.in_valid  = 1'b1;
          tick();
          chk_d("rnd_bp_state", bus.state_q, exp_s);
        end
        idle_inputs();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk_idle("rnd_ret");
        chk_d("rnd_keep", bus.state_q, exp_s);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/round_state_mux.md
ROUND_STATE_MUX -- requirements
Module: round_state_mux

Interface
Parameters (name, default, meaning):
REQ-001 WORD_W, 32, bit width of one state word.
REQ-002 NWORDS, 4, number of state words (channels) held and selected.
REQ-003 NROUNDS, 10, number of feedback rounds per block; legal range 1..(2**CNT_W)-1.
REQ-004 CNT_W, 4, width of the round counter.
Ports (name, direction, width, meaning):
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 abort  input  1  synchronous clear to IDLE, active-high.
REQ-008 in_valid  input  1  initial block offered.
REQ-009 in_ready  output  1  block accepted when in_valid and in_ready are both high on a clk edge.
REQ-010 in_data  input  WORD_W*NWORDS  initial state; word k = bits [k*WORD_W +: WORD_W].
REQ-011 fb_data  input  WORD_W*NWORDS  round-function result computed from state_q; same packing.
REQ-012 key_valid  input  1  round key for the current round is available; advance enable.
REQ-013 state_q  output  WORD_W*NWORDS  registered selected state; drives the round function.
REQ-014 round  output  CNT_W  current round number, registered.
REQ-015 busy  output  1  high in RUN.
REQ-016 out_valid  output  1  final state available on state_q.
REQ-017 out_ready  input  1  consumer takes the final state.

Function
REQ-018 FSM states: IDLE, RUN, DONE; encoding is free; all outputs are registered or decoded from registered state only.
REQ-019 IDLE: in_ready=1, busy=0, out_valid=0; on handshake load state_q<=in_data, round<=1, go RUN.
REQ-020 IDLE without handshake: state_q and round hold.
REQ-021 RUN: in_ready=0, busy=1; on a cycle with key_valid=1, state_q<=fb_data on all NWORDS words together.
REQ-022 RUN with key_valid=1 and round<NROUNDS: round<=round+1, stay RUN.
REQ-023 RUN with key_valid=1 and round==NROUNDS: round holds at NROUNDS, go DONE.
REQ-024 RUN with key_valid=0: state_q and round hold (stall); stall length unbounded.
REQ-025 Selection rule: state_q loads in_data only on the IDLE handshake; every other load takes fb_data; partial-word updates never occur.
REQ-026 DONE: out_valid=1, in_ready=0, busy=0; state_q holds the final state stable until the out_ready handshake.
REQ-027 DONE with out_ready=1: round<=0, go IDLE; state_q keeps the final value.
REQ-028 Latency with key_valid tied high: out_valid rises exactly NROUNDS clk edges after the acceptance edge.
REQ-029 Throughput: one block in flight; the next in_valid is accepted no earlier than the cycle after the DONE->IDLE edge.
REQ-030 abort=1 in any state: next edge go IDLE, round<=0, state_q<=0; abort has priority over handshakes and key_valid.
REQ-031 in_valid, fb_data and key_valid are ignored outside the states that use them; out_ready is ignored outside DONE.
REQ-032 round never exceeds NROUNDS and never wraps.

Reset
REQ-033 rst=1 asynchronously forces IDLE, state_q=0, round=0, in_ready=1, busy=0, out_valid=0, with no dependence on clk.
REQ-034 rst asserted mid-RUN or in DONE discards the block; after release the first edge behaves as IDLE.
REQ-035 Reset release is followed by normal operation on the next rising clk edge.

Verification (WORD_W=32, NWORDS=4, NROUNDS=10)
REQ-036 Nominal: in_data=00112233_44556677_8899AABB_CCDDEEFF, key_valid=1, fb_data=state_q+1 per word -> out_valid 10 edges after accept, state_q words = input words +10, round=10.
REQ-037 Stall: key_valid low for 3 cycles at round=4 -> state_q and round frozen for 3 cycles, out_valid 13 edges after accept.
REQ-038 Backpressure: out_ready low for 5 cycles in DONE -> state_q stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE, round=0.
REQ-039 Abort at round=6 -> next edge IDLE, state_q=0, round=0, in_ready=1; a new block is then accepted normally.
REQ-040 Async reset pulse between clk edges during RUN -> outputs reach reset values immediately, before any clk edge.
REQ-041 Back-to-back: in_valid held high across two blocks -> second block accepted on the first IDLE cycle after the first completes, its round 1 state = its in_data.
